// File: rtl/upsampling_pkg.sv
// upsampling_pkg: shared FSM state type and default sizing for the line scheduler
package upsampling_pkg;
    localparam int DEF_CNT_W           = 12;
    localparam int DEF_GAP_CYCLES      = 20;
    localparam int DEF_MAX_OUTSTANDING = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DRAIN} state_t;
endpackage

// File: rtl/upsampling_gap_timer.sv
// upsampling_gap_timer: loadable down-counter that flags when the inter-line gap has elapsed
module upsampling_gap_timer
    import upsampling_pkg::*;
#(
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_expired
);
    localparam int W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Loading GAP_CYCLES-1 makes expired assert in the GAP_CYCLES-th cycle after the load edge
    localparam logic [W-1:0] LOAD = W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    logic [W-1:0] r_cnt;
    // Reload on every end of line, otherwise count down to zero and stay there
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= LOAD;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end
    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/upsampling_line_scheduler.sv
// upsampling_line_scheduler: frames a pass-through stream into lines with gaps and upsampler backpressure
module upsampling_line_scheduler
    import upsampling_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int CNT_W              = DEF_CNT_W,
    parameter int GAP_CYCLES         = DEF_GAP_CYCLES,
    parameter int MAX_OUTSTANDING    = DEF_MAX_OUTSTANDING
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CNT_W-1:0]              line_words,
    input  logic [CNT_W-1:0]              frame_lines,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          err_early_last,
    output logic                          err_cfg,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    input  logic                          up_tvalid,
    input  logic                          up_tready,
    input  logic                          up_tlast
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);
    state_t           r_state;
    logic [CNT_W-1:0] r_line_words;
    logic [CNT_W-1:0] r_frame_lines;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [OW-1:0]    r_outstanding;
    logic             r_frame_done;
    logic             r_err_early_last;
    logic             r_err_cfg;
    logic             w_run;
    logic             w_beat;
    logic             w_at_end;
    logic             w_eol;
    logic             w_early;
    logic             w_up_last;
    logic             w_cfg_ok;
    logic             w_start;
    logic             w_gap_expired;
    // Gating with rst_n keeps every output low while reset is held, even before the first edge
    assign w_run         = rst_n && (r_state == ST_RUN);
    assign w_beat        = w_run && s_axis_tvalid && m_axis_tready;
    assign w_at_end      = (r_word_cnt == r_line_words - CNT_W'(1));
    assign w_eol         = w_beat && (w_at_end || s_axis_tlast);
    assign w_early       = w_beat && s_axis_tlast && (r_word_cnt < r_line_words - CNT_W'(1));
    assign w_up_last     = up_tvalid && up_tready && up_tlast;
    assign w_cfg_ok      = (line_words > CNT_W'(1)) && (frame_lines != '0);
    assign w_start       = (r_state == ST_IDLE) && start && !abort && w_cfg_ok;
    assign busy          = rst_n && (r_state != ST_IDLE);
    assign s_axis_tready = w_run && m_axis_tready;
    assign m_axis_tvalid = w_run && s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = w_run && (w_at_end || s_axis_tlast);
    assign frame_done     = rst_n && r_frame_done;
    assign err_early_last = rst_n && r_err_early_last;
    assign err_cfg        = rst_n && r_err_cfg;
    upsampling_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_eol),
        .o_expired (w_gap_expired)
    );
    // Lines handed to the upsampler but not yet seen leaving it; a coincident end and return cancel
    always_ff @(posedge clk) begin
        if (!rst_n || abort || w_start)
            r_outstanding <= '0;
        else if (w_eol && !w_up_last)
            r_outstanding <= r_outstanding + OW'(1);
        else if (!w_eol && w_up_last && r_outstanding != '0)
            r_outstanding <= r_outstanding - OW'(1);
    end
    // Frame control FSM with line/word counters and registered status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_line_words     <= '0;
            r_frame_lines    <= '0;
            r_word_cnt       <= '0;
            r_line_cnt       <= '0;
            r_frame_done     <= 1'b0;
            r_err_early_last <= 1'b0;
            r_err_cfg        <= 1'b0;
        end else begin
            r_frame_done     <= 1'b0;
            r_err_early_last <= w_early;
            r_err_cfg        <= 1'b0;
            if (abort) begin
                r_state    <= ST_IDLE;
                r_word_cnt <= '0;
                r_line_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_line_words  <= line_words;
                            r_frame_lines <= frame_lines;
                            r_word_cnt    <= '0;
                            r_line_cnt    <= '0;
                            r_state       <= ST_RUN;
                        end else if (start) begin
                            r_err_cfg <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_eol) begin
                            r_word_cnt <= '0;
                            r_line_cnt <= r_line_cnt + CNT_W'(1);
                            r_state    <= ST_GAP;
                        end else if (w_beat) begin
                            r_word_cnt <= r_word_cnt + CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_expired && r_outstanding != OMAX)
                            r_state <= (r_line_cnt < r_frame_lines) ? ST_RUN : ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (r_outstanding == '0) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_upsampling_line_scheduler.sv
// tb_upsampling_line_scheduler: random stream and upsampler model checked against line/frame rules
module tb_upsampling_line_scheduler;
    localparam int GAP = 20;
    localparam int MAXO = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] line_words = '0;
    logic [11:0] frame_lines = '0;
    logic        busy, frame_done, err_early_last, err_cfg;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic        up_tvalid = 1'b0;
    logic        up_tready = 1'b0;
    logic        up_tlast = 1'b0;
    int checks = 0;
    int failures = 0;

    upsampling_line_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .line_words(line_words), .frame_lines(frame_lines),
        .busy(busy), .frame_done(frame_done), .err_early_last(err_early_last), .err_cfg(err_cfg),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .up_tvalid(up_tvalid), .up_tready(up_tready), .up_tlast(up_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_up(input logic v);
        up_tvalid = v;
        up_tready = v;
        up_tlast  = v;
    endtask

    // One frame: the bench tracks lines, words, gap length and the upsampler's outstanding lines itself
    task automatic run_frame(input int lw, input int fl, input int early_line, input int early_beat,
                             input bit rnd_v, input bit rnd_r, input int up_delay,
                             input bit coincide, input bit stray, input int hold_until);
        int q[$];
        int line = 0, bil = 0, eol = 0, dlv = 0, idle = -1, out_now;
        int budget = fl * (lw * 8 + GAP + 60) + up_delay + hold_until + 300;
        bit err_pend = 0, beat, exp_last, from_q, fire, done = 0;
        @(posedge clk); #1;
        line_words = 12'(lw); frame_lines = 12'(fl); start = 1'b1; s_axis_tvalid = 1'b0; set_up(1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            s_axis_tvalid = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_axis_tready = rnd_r ? ($urandom_range(0, 4) != 0) : 1'b1;
            s_axis_tdata  = $urandom;
            s_axis_tlast  = (line == early_line && bil == early_beat) || (bil == lw - 1 && $urandom_range(0, 1) == 1);
            #1;
            beat     = s_axis_tvalid && s_axis_tready;
            exp_last = (bil == lw - 1) || s_axis_tlast;
            from_q   = q.size() > 0 && q[0] <= n && n >= hold_until;
            if (coincide && beat && exp_last && line >= 1 && q.size() > 0) from_q = 1'b1;
            fire = from_q || (stray && n == 5);
            set_up(fire);
            @(negedge clk);
            out_now = eol - dlv;
            chk("err_early_last", err_early_last, err_pend);
            err_pend = beat && s_axis_tlast && bil < lw - 1;
            if (frame_done) begin
                chk("done_after_drain", line == fl && q.size() == 0, 1);
                done = 1'b1;
            end else chk("busy_in_frame", busy, 1);
            if (s_axis_tready) begin
                chk("pass_tvalid", m_axis_tvalid, s_axis_tvalid);
                if (idle >= 0) begin
                    chk("gap_min_len", idle >= GAP, 1);
                    chk("gap_backpressure", out_now < MAXO, 1);
                    chk("line_remaining", line < fl, 1);
                    idle = -1;
                end
            end else if (m_axis_tready) chk("tvalid_blocked", m_axis_tvalid, 0);
            if (beat) begin
                chk("tlast", m_axis_tlast, exp_last);
                chk("tdata", m_axis_tdata, s_axis_tdata);
                if (exp_last) begin
                    line++; bil = 0; eol++; idle = 0;
                    q.push_back(n + up_delay);
                end else bil++;
            end else if (idle >= 0) idle++;
            if (from_q) begin
                void'(q.pop_front());
                dlv++;
            end
            if (hold_until > 0 && n == hold_until - 1) begin
                chk("held_lines", line, 2);
                chk("held_ready", s_axis_tready, 0);
            end
            @(posedge clk); #1;
        end
        set_up(1'b0); s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        chk("frame_done_seen", done, 1);
        chk("lines_done", line, fl);
        @(negedge clk);
        chk("idle_after_done", busy, 0);
        chk("done_one_pulse", frame_done, 0);
    endtask

    initial begin
        int beats, fd, lw, fl;
        // Reset state with stream inputs active
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1; s_axis_tlast = 1'b1; start = 1'b1;
        line_words = 12'd600; frame_lines = 12'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_early", err_early_last, 0);
        chk("rst_err_cfg", err_cfg, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        // Invalid configurations
        line_words = 12'd1; frame_lines = 12'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("cfg_lw1_err", err_cfg, 1);
        chk("cfg_lw1_busy", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cfg_err_pulse", err_cfg, 0);
        @(posedge clk); #1;
        line_words = 12'd10; frame_lines = 12'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("cfg_fl0_err", err_cfg, 1);
        chk("cfg_fl0_busy", busy, 0);
        // Abort wins over a simultaneous valid start
        @(posedge clk); #1;
        line_words = 12'd10; frame_lines = 12'd1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_err", err_cfg, 0);
        // Nominal frames, early tlast, upsampler backpressure, coincident return
        run_frame(600, 2, -1, -1, 1'b0, 1'b0, 50, 1'b0, 1'b1, 0);
        run_frame(600, 2, 0, 299, 1'b1, 1'b0, 50, 1'b0, 1'b0, 0);
        run_frame(40, 4, -1, -1, 1'b1, 1'b1, 30, 1'b0, 1'b0, 400);
        run_frame(40, 2, -1, -1, 1'b0, 1'b0, 200, 1'b1, 1'b0, 0);
        run_frame(2, 3, 1, 0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            lw = $urandom_range(2, 80);
            fl = $urandom_range(1, 5);
            run_frame(lw, fl, $urandom_range(0, fl - 1), $urandom_range(0, lw - 2), 1'b1, 1'b1,
                      $urandom_range(0, 60), 1'b0, 1'b0, 0);
        end
        // Reset in the middle of a line
        @(posedge clk); #1;
        line_words = 12'd600; frame_lines = 12'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        beats = 0;
        for (int n = 0; n < 2000 && beats < 250; n++) begin
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) beats++;
            @(posedge clk); #1;
        end
        chk("reached_word_250", beats, 250);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_tvalid", m_axis_tvalid, 0);
        chk("rst_mid_tready", s_axis_tready, 0);
        chk("rst_mid_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; s_axis_tvalid = 1'b0;
        run_frame(600, 1, -1, -1, 1'b1, 1'b0, 20, 1'b0, 1'b0, 0);
        // Abort while draining; late upsampler return and a stray start must not produce anything
        @(posedge clk); #1;
        line_words = 12'd30; frame_lines = 12'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        repeat (70) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_tready", s_axis_tready, 0);
        @(posedge clk); #1;
        line_words = 12'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_ignored_busy", err_cfg, 0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        fd = 0;
        @(posedge clk); #1;
        set_up(1'b1);
        @(posedge clk); #1;
        set_up(1'b0);
        repeat (40) begin
            @(negedge clk);
            if (frame_done) fd++;
            @(posedge clk); #1;
        end
        chk("no_done_after_abort", fd, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/upsampling_line_scheduler.md
UPSAMPLING_LINE_SCHEDULER -- requirements
Module: upsampling_line_scheduler

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 32: stream data width, identical on s_axis and m_axis.
REQ-002 SHALL have parameter CNT_W, default 12: width of the words-per-line and lines-per-frame counters.
REQ-003 SHALL have parameter GAP_CYCLES, default 20: minimum idle cycles between consecutive lines.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2: maximum lines accepted but not yet emitted by the upsampler.
REQ-005 SHALL have ports: clk in 1, the single clock; rst_n in 1, reset, synchronous and active-low.
REQ-006 SHALL have ports: start in 1, frame-start pulse; abort in 1, synchronous frame abort.
REQ-007 SHALL have ports: line_words in CNT_W, words per line; frame_lines in CNT_W, lines per frame.
REQ-008 SHALL have ports: busy out 1; frame_done out 1, one-cycle pulse; err_early_last out 1, one-cycle pulse; err_cfg out 1, one-cycle pulse.
REQ-009 SHALL have upstream ports: s_axis_tdata in C_AXIS_TDATA_WIDTH; s_axis_tvalid in 1; s_axis_tlast in 1; s_axis_tready out 1.
REQ-010 SHALL have upsampler-input ports: m_axis_tdata out C_AXIS_TDATA_WIDTH; m_axis_tvalid out 1; m_axis_tlast out 1; m_axis_tready in 1.
REQ-011 SHALL have upsampler-output monitor ports: up_tvalid in 1; up_tready in 1; up_tlast in 1.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, GAP, DRAIN; busy=1 in every state except IDLE.
REQ-013 In IDLE, start=1 with line_words>=2 and frame_lines>=1 SHALL latch both values, clear the counters, and enter RUN on the next cycle.
REQ-014 In IDLE, start=1 with an invalid configuration SHALL pulse err_cfg, ignore the start, and remain in IDLE.
REQ-015 In RUN, the block SHALL pass the stream through combinationally with zero latency: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, m_axis_tdata=s_axis_tdata.
REQ-016 A beat SHALL be defined as s_axis_tvalid & m_axis_tready while in RUN; word_cnt SHALL increment on every beat.
REQ-017 m_axis_tlast SHALL be 1 on the beat with word_cnt==line_words-1, or on any beat with s_axis_tlast=1.
REQ-018 If s_axis_tlast=1 on a beat where word_cnt<line_words-1, the block SHALL pulse err_early_last and treat that beat as the end of the line.
REQ-019 A missing s_axis_tlast at the line end SHALL NOT be reported as an error; the generated m_axis_tlast alone ends the line.
REQ-020 On the end-of-line beat, the block SHALL clear word_cnt, increment line_cnt and outstanding, and enter GAP.
REQ-021 In GAP and DRAIN, s_axis_tready and m_axis_tvalid SHALL both be 0.
REQ-022 GAP SHALL last at least GAP_CYCLES cycles and SHALL additionally hold while outstanding==MAX_OUTSTANDING.
REQ-023 On leaving GAP, the block SHALL enter RUN if line_cnt<frame_lines, otherwise DRAIN.
REQ-024 outstanding SHALL decrement on up_tvalid & up_tready & up_tlast; simultaneous increment and decrement SHALL leave it unchanged.
REQ-025 outstanding SHALL saturate at 0; an extra up_tlast in that case SHALL be ignored.
REQ-026 In DRAIN, when outstanding==0 the block SHALL pulse frame_done for one cycle and return to IDLE.
REQ-027 In IDLE, start=1 together with abort=1 SHALL give priority to abort: the start is ignored.
REQ-028 abort=1 in any state SHALL return the FSM to IDLE on the next edge, clear all counters, and suppress frame_done.
REQ-029 start in any state other than IDLE SHALL be ignored.

Reset
REQ-030 With rst_n=0 at a rising clk edge, the FSM SHALL enter IDLE and word_cnt, line_cnt, outstanding and the latched configuration SHALL be cleared.
REQ-031 During reset, busy, frame_done, err_early_last, err_cfg, s_axis_tready, m_axis_tvalid and m_axis_tlast SHALL all be 0.
REQ-032 Reset mid-line SHALL drop m_axis_tvalid at that same edge; no partial-line completion SHALL follow.

Structure
REQ-033 The shared package upsampling_pkg SHALL hold the FSM state enum and the default values of CNT_W, GAP_CYCLES and MAX_OUTSTANDING.
REQ-034 The gap counter SHALL be the single sub-module upsampling_gap_timer: load, count down, expired flag.

Verification
REQ-035 line_words=600, frame_lines=2, m_axis_tready=1, up_tlast after 50 cycles -> m_axis_tlast on beats 600 and 1200, >=20 idle cycles between lines, one frame_done.
REQ-036 s_axis_tlast on beat 300 of a 600-word line -> err_early_last pulse, m_axis_tlast on beat 300, next line starts after the gap.
REQ-037 up_tlast withheld, frame_lines=4 -> after 2 lines the FSM stays in GAP with s_axis_tready=0; releasing one up_tlast starts line 3.
REQ-038 start with line_words=1 -> err_cfg pulse, busy stays 0.
REQ-039 rst_n=0 at word 250 -> m_axis_tvalid=0 at the next edge; a new start gives a full 600-word line.
REQ-040 abort during DRAIN; and up_tlast coinciding with end-of-line -> no frame_done after the abort; outstanding unchanged in the coincident cycle.
